wb_stage: RTL and testbench

//  Writeback stage of the NPC core. Accepts one retired instruction from the execute/LSU side

---
 rtl/npc_pkg.sv | 22 ++
 rtl/load_ext.sv | 39 +++
 rtl/wb_stage.sv | 111 +++++++++++
 tb/tb_wb_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared NPC core definitions: writeback select encodings, load funct3 codes
// and the writeback-stage state encoding.
package npc_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_CSR  = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_IDLE     = 2'd0,
    WB_WAIT_MEM = 2'd1,
    WB_WRITE    = 2'd2
  } wb_state_e;

endpackage

// File: rtl/load_ext.sv
// Combinational load extraction: picks the byte/half addressed by off out of
// an aligned 32-bit word and sign- or zero-extends it according to funct3.
module load_ext
  import npc_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  end

  // Halves are selected by off[1] only; off[0] is ignored for halfword loads.
  assign half_sel = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts one retired instruction, waits for load data when
// needed, then writes the register file and pulses commit for one cycle.
module wb_stage
  import npc_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // Upstream handshake: a transfer happens on a rising edge where in_valid and
  // in_ready are both high; in_ready depends only on state, never on in_valid.
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic [1:0]            in_wb_sel,
  input  logic [DATA_WIDTH-1:0] in_alu_res,
  input  logic [DATA_WIDTH-1:0] in_csr_rdata,
  input  logic [2:0]            in_funct3,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  commit_valid,
  output logic [DATA_WIDTH-1:0] commit_pc,
  output logic [1:0]            dbg_state,
  output logic [1:0]            dbg_sel
);

  wb_state_e state, state_next;

  logic [DATA_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  rd_wen_q;
  logic [1:0]            sel_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic [DATA_WIDTH-1:0] sel_res;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  accept;

  assign in_ready = (state == WB_IDLE);
  assign accept   = in_valid && in_ready;

  // For loads res_q carries the effective address until data arrives, so the
  // byte offset is taken from it during WAIT_MEM.
  always_comb begin
    sel_res = in_alu_res;
    case (in_wb_sel)
      WB_SEL_ALU:  sel_res = in_alu_res;
      WB_SEL_LOAD: sel_res = in_alu_res;
      WB_SEL_PC4:  sel_res = in_pc + DATA_WIDTH'(4);
      default:     sel_res = in_csr_rdata;
    endcase
  end

  load_ext u_load_ext (
    .word   (mem_rdata),
    .off    (res_q[1:0]),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= WB_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WB_IDLE:     if (in_valid)
                     state_next = (in_wb_sel == WB_SEL_LOAD) ? WB_WAIT_MEM : WB_WRITE;
      WB_WAIT_MEM: if (mem_rvalid) state_next = WB_WRITE;
      WB_WRITE:    state_next = WB_IDLE;
      default:     state_next = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      rd_q     <= '0;
      rd_wen_q <= 1'b0;
      sel_q    <= '0;
      funct3_q <= '0;
      res_q    <= '0;
    end else if (accept) begin
      pc_q     <= in_pc;
      rd_q     <= in_rd;
      rd_wen_q <= in_rd_wen;
      sel_q    <= in_wb_sel;
      funct3_q <= in_funct3;
      res_q    <= sel_res;
    end else if (state == WB_WAIT_MEM && mem_rvalid) begin
      res_q    <= load_data;
    end
  end

  assign rf_wen       = (state == WB_WRITE) && rd_wen_q && (rd_q != '0);
  assign rf_waddr     = rd_q;
  assign rf_wdata     = res_q;
  assign commit_valid = (state == WB_WRITE);
  assign commit_pc    = pc_q;
  assign dbg_state    = state;
  assign dbg_sel      = sel_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: scoreboard of expected commits checked by a
// negedge monitor, plus timing/boundary checks in one linear initial block.
module tb_wb_stage;

  localparam int EW = 70;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [4:0]  in_rd = '0;
  logic        in_rd_wen = 1'b0;
  logic [1:0]  in_wb_sel = '0;
  logic [31:0] in_alu_res = '0;
  logic [31:0] in_csr_rdata = '0;
  logic [2:0]  in_funct3 = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_sel;

  int checks = 0;
  int errors = 0;
  int commits = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int prev_cyc = 0;
  logic [EW-1:0] exp_q[$];

  wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_rd        (in_rd),
    .in_rd_wen    (in_rd_wen),
    .in_wb_sel    (in_wb_sel),
    .in_alu_res   (in_alu_res),
    .in_csr_rdata (in_csr_rdata),
    .in_funct3    (in_funct3),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .dbg_state    (dbg_state),
    .dbg_sel      (dbg_sel)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference load extraction written from the ISA definition.
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((w >> (8 * off)) & 32'hFF);
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: presents one instruction, waits (bounded) for acceptance, and for
  // loads supplies the data word after 'waits' idle cycles. Returns one step
  // after the edge that puts the stage in WRITE.
  task automatic send(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                      input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] csr,
                      input logic [2:0] f3, input logic [31:0] mdata, input int waits,
                      input bit hold);
    logic [31:0] wd;
    int n;
    case (sel)
      2'd0:    wd = alu;
      2'd1:    wd = model_load(mdata, alu[1:0], f3);
      2'd2:    wd = pc + 32'd4;
      default: wd = csr;
    endcase
    in_valid = 1'b1; in_pc = pc; in_rd = rd; in_rd_wen = wen; in_wb_sel = sel;
    in_alu_res = alu; in_csr_rdata = csr; in_funct3 = f3;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk("accept_ready", in_ready, 1'b1);
    exp_q.push_back({wen && (rd != 5'd0), rd, wd, pc});
    tick();
    accept_cyc = cyc;
    if (sel == 2'd1) begin
      in_valid = 1'b0;
      chk("load_wait_state", dbg_state, 2'd1);
      repeat (waits) tick();
      mem_rvalid = 1'b1; mem_rdata = mdata;
      tick();
      mem_rvalid = 1'b0;
    end
    if (!hold) in_valid = 1'b0;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (commit_valid) begin
        logic [EW-1:0] e;
        commits++;
        chk("commit_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("commit_data", {rf_wen, rf_waddr, rf_wdata, commit_pc}, e);
        end
      end else begin
        chk("wen_only_in_write", rf_wen, 1'b0);
      end
    end
  end

  initial begin
    int base;
    // reset
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_rf_wen", rf_wen, 1'b0);
    chk("rst_waddr", rf_waddr, 5'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_commit", commit_valid, 1'b0);
    chk("rst_commit_pc", commit_pc, 32'd0);
    rst = 1'b0;
    tick();

    // 1. ALU write and latency
    send(32'h0000_1000, 5'd5, 1'b1, 2'd0, 32'h1234_5678, 32'd0, 3'b000, 32'd0, 0, 1'b0);
    chk("alu_state_write", dbg_state, 2'd2);
    chk("alu_rf_wen", rf_wen, 1'b1);
    chk("alu_waddr", rf_waddr, 5'd5);
    chk("alu_wdata", rf_wdata, 32'h1234_5678);
    chk("alu_commit_pc", commit_pc, 32'h0000_1000);
    chk("alu_ready_low", in_ready, 1'b0);
    tick();
    chk("alu_ready_n2", in_ready, 1'b1);
    chk("alu_commit_drop", commit_valid, 1'b0);

    // 2. loads
    send(32'h0000_2000, 5'd6, 1'b1, 2'd1, 32'h0000_0103, 32'd0, 3'b000, 32'h80FF_FF00, 3, 1'b0);
    chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    tick();
    send(32'h0000_2004, 5'd7, 1'b1, 2'd1, 32'h0000_0103, 32'd0, 3'b100, 32'h80FF_FF00, 3, 1'b0);
    chk("lbu_wdata", rf_wdata, 32'h0000_0080);
    tick();
    send(32'h0000_2008, 5'd8, 1'b1, 2'd1, 32'h0000_0102, 32'd0, 3'b101, 32'h80FF_FF00, 1, 1'b0);
    chk("lhu_wdata", rf_wdata, 32'h0000_80FF);
    tick();
    send(32'h0000_200C, 5'd9, 1'b1, 2'd1, 32'h0000_0100, 32'd0, 3'b001, 32'h80FF_FF00, 0, 1'b0);
    chk("lh_wdata", rf_wdata, 32'hFFFF_FF00);
    tick();
    send(32'h0000_2010, 5'd10, 1'b1, 2'd1, 32'h0000_0103, 32'd0, 3'b010, 32'hCAFE_F00D, 2, 1'b0);
    chk("lw_wdata", rf_wdata, 32'hCAFE_F00D);
    tick();
    send(32'h0000_2014, 5'd11, 1'b1, 2'd1, 32'h0000_0101, 32'd0, 3'b011, 32'h8765_4321, 0, 1'b0);
    chk("odd_f3_wdata", rf_wdata, 32'h8765_4321);
    tick();

    // 3. rd==0: commit without RF write
    send(32'h0000_3000, 5'd0, 1'b1, 2'd0, 32'h5555_AAAA, 32'd0, 3'b000, 32'd0, 0, 1'b0);
    chk("rd0_rf_wen", rf_wen, 1'b0);
    chk("rd0_commit", commit_valid, 1'b1);
    tick();
    chk("rd0_commit_one_cycle", commit_valid, 1'b0);

    // 4. PC+4 wrap and CSR
    send(32'hFFFF_FFFC, 5'd1, 1'b1, 2'd2, 32'h1111_1111, 32'd0, 3'b000, 32'd0, 0, 1'b0);
    chk("pc4_wrap", rf_wdata, 32'h0000_0000);
    tick();
    send(32'h0000_4000, 5'd2, 1'b1, 2'd3, 32'h2222_2222, 32'hDEAD_BEEF, 3'b000, 32'd0, 0, 1'b0);
    chk("csr_wdata", rf_wdata, 32'hDEAD_BEEF);
    tick();

    // 5. reset during WAIT_MEM, then a late mem_rvalid
    base = commits;
    in_valid = 1'b1; in_pc = 32'h0000_5000; in_rd = 5'd12; in_rd_wen = 1'b1;
    in_wb_sel = 2'd1; in_alu_res = 32'h0000_0000; in_funct3 = 3'b010;
    tick();
    in_valid = 1'b0;
    chk("rstmid_wait_state", dbg_state, 2'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_state_idle", dbg_state, 2'd0);
    chk("rstmid_ready", in_ready, 1'b1);
    mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
    tick();
    mem_rvalid = 1'b0;
    chk("late_rvalid_idle", dbg_state, 2'd0);
    repeat (2) tick();
    chk("rstmid_no_commit", commits, base);

    // 6. stray mem_rvalid in IDLE, then 4 back-to-back instructions
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("stray_rvalid_state", dbg_state, 2'd0);
    send(32'h0000_6000, 5'd13, 1'b1, 2'd0, 32'hA000_0001, 32'd0, 3'b000, 32'd0, 0, 1'b1);
    prev_cyc = accept_cyc;
    send(32'h0000_6004, 5'd14, 1'b1, 2'd0, 32'hA000_0002, 32'd0, 3'b000, 32'd0, 0, 1'b1);
    chk("b2b_gap_1", accept_cyc - prev_cyc, 2);
    prev_cyc = accept_cyc;
    send(32'h0000_6008, 5'd15, 1'b1, 2'd2, 32'hA000_0003, 32'd0, 3'b000, 32'd0, 0, 1'b1);
    chk("b2b_gap_2", accept_cyc - prev_cyc, 2);
    prev_cyc = accept_cyc;
    send(32'h0000_600C, 5'd16, 1'b1, 2'd3, 32'hA000_0004, 32'hBEEF_0004, 3'b000, 32'd0, 0, 1'b0);
    chk("b2b_gap_3", accept_cyc - prev_cyc, 2);
    repeat (3) tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("commit_count", commits, 14);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
